// File: rtl/video_udp_pkg.sv
// Shared types and constants for the video FIFO -> UDP byte packer.
// Header layout: frame seq (LE), then packet seq (LE).
package video_udp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_HDR,
        ST_PAY,
        ST_DONE
    } state_t;

    localparam int HDR_BYTES = 4;

    function automatic int pkt_bytes(input int words);
        return HDR_BYTES + words * 5 / 4;
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] frm,
                                            input logic [15:0] pkt);
        case (idx)
            2'd0:    return frm[7:0];
            2'd1:    return frm[15:8];
            2'd2:    return pkt[7:0];
            default: return pkt[15:8];
        endcase
    endfunction

endpackage

// File: rtl/video_gear_10to8.sv
// 10-bit word -> byte gearbox: read issued one cycle before the word lands, one byte/cycle out.
// Output byte held while ready is low; reads throttle so the 48-bit accumulator never overflows.
module video_gear_10to8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] words_left,
    input  logic [9:0]  din,
    output logic        rd_en,
    output logic [7:0]  dout,
    output logic        valid,
    input  logic        ready
);
    import video_udp_pkg::*;

    logic [47:0] acc;
    logic [5:0]  cnt;
    logic [5:0]  base;
    logic        inflight;
    logic        accept;

    assign valid  = enable && (cnt >= 6'd8);
    assign accept = valid && ready;
    assign dout   = acc[7:0];

    // Reserve room for the word already in flight plus the one about to be requested.
    assign rd_en = enable && (words_left != 16'd0)
                   && (({1'b0, cnt} + (inflight ? 7'd20 : 7'd10)) <= 7'd48);

    assign base = accept ? (cnt - 6'd8) : cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            acc      <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
            acc      <= (accept ? (acc >> 8) : acc)
                        | (inflight ? ({38'd0, din} << base) : 48'd0);
            cnt      <= base + (inflight ? 6'd10 : 6'd0);
        end
    end

endmodule

// File: rtl/video_udp_packer.sv
// Video FIFO -> UDP byte stream: 4-byte seq header then PKT_WORDS*5/4 packed payload bytes; stalls only on udp_tx_ready.
// VIDEO_PACKER_TEST_PATTERN_EN replaces FIFO data with an internal word counter and ignores video_rd_rdy.
module video_udp_packer #(
    parameter int PKT_WORDS     = 1024,
    parameter int PKT_PER_FRAME = 1800
) (
    input  logic        video_rd_clk,
    input  logic        rst_n,
    input  logic        video_rd_rdy,
    output logic        video_rd_en,
    input  logic [9:0]  video_rd_data,
    output logic        udp_tx_start,
    output logic [15:0] udp_tx_byte_num,
    output logic [7:0]  udp_tx_data,
    output logic        udp_tx_valid,
    input  logic        udp_tx_ready,
    output logic        udp_tx_last,
    input  logic        udp_tx_done
);
    import video_udp_pkg::*;

    localparam logic [15:0] PKT_BYTES = 16'(pkt_bytes(PKT_WORDS));
    localparam logic [15:0] PAY_BYTES = 16'(PKT_WORDS * 5 / 4);

    state_t      state, state_nxt;
    logic [1:0]  hdr_idx;
    logic [15:0] words_left, bytes_left, pkt_seq, frm_seq;
    logic        g_rd_en, g_vld, go;
    logic [7:0]  g_dat;
    logic [9:0]  word;

`ifdef VIDEO_PACKER_TEST_PATTERN_EN
    logic [9:0] tp_cnt;
    logic       tp_land;
    logic       unused_fifo;

    always_ff @(posedge video_rd_clk) begin
        if (!rst_n) begin
            tp_cnt  <= '0;
            tp_land <= 1'b0;
        end else begin
            tp_land <= g_rd_en;
            if (tp_land) tp_cnt <= tp_cnt + 10'd1;
        end
    end

    assign word        = tp_cnt;
    assign go          = 1'b1;
    assign video_rd_en = 1'b0;
    assign unused_fifo = ^{video_rd_rdy, video_rd_data};
`else
    assign word        = video_rd_data;
    assign go          = video_rd_rdy;
    assign video_rd_en = g_rd_en;
`endif

    video_gear_10to8 u_gear (
        .clk        (video_rd_clk),
        .rst_n      (rst_n),
        .enable     (state == ST_PAY),
        .words_left (words_left),
        .din        (word),
        .rd_en      (g_rd_en),
        .dout       (g_dat),
        .valid      (g_vld),
        .ready      (udp_tx_ready)
    );

    always_ff @(posedge video_rd_clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        udp_tx_start = 1'b0;
        udp_tx_valid = 1'b0;
        udp_tx_data  = 8'd0;
        udp_tx_last  = 1'b0;
        case (state)
            ST_IDLE:  state_nxt = ST_WAIT;
            ST_WAIT:  if (go) state_nxt = ST_START;
            ST_START: begin
                udp_tx_start = 1'b1;
                state_nxt    = ST_HDR;
            end
            ST_HDR: begin
                udp_tx_valid = 1'b1;
                udp_tx_data  = hdr_byte(hdr_idx, frm_seq, pkt_seq);
                if (udp_tx_ready && hdr_idx == 2'(HDR_BYTES - 1)) state_nxt = ST_PAY;
            end
            ST_PAY: begin
                udp_tx_valid = g_vld;
                udp_tx_data  = g_dat;
                udp_tx_last  = g_vld && (bytes_left == 16'd1);
                if (udp_tx_last && udp_tx_ready) state_nxt = ST_DONE;
            end
            ST_DONE:  if (udp_tx_done) state_nxt = ST_WAIT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge video_rd_clk) begin
        if (!rst_n) begin
            udp_tx_byte_num <= '0;
            hdr_idx         <= '0;
            words_left      <= '0;
            bytes_left      <= '0;
            pkt_seq         <= '0;
            frm_seq         <= '0;
        end else begin
            udp_tx_byte_num <= PKT_BYTES;
            case (state)
                ST_START: begin
                    hdr_idx    <= '0;
                    words_left <= 16'(PKT_WORDS);
                    bytes_left <= PAY_BYTES;
                end
                ST_HDR: if (udp_tx_ready) hdr_idx <= hdr_idx + 2'd1;
                ST_PAY: begin
                    if (g_rd_en) words_left <= words_left - 16'd1;
                    if (g_vld && udp_tx_ready) bytes_left <= bytes_left - 16'd1;
                end
                ST_DONE: if (udp_tx_done) begin
                    if (pkt_seq == 16'(PKT_PER_FRAME - 1)) begin
                        pkt_seq <= '0;
                        frm_seq <= frm_seq + 16'd1;
                    end else begin
                        pkt_seq <= pkt_seq + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_video_udp_packer.sv
module tb_video_udp_packer;

    localparam int PKT_BYTES     = 1284;
    localparam int PKT_PER_FRAME = 1800;
`ifdef VIDEO_PACKER_TEST_PATTERN_EN
    localparam int EXP_READS = 0;
`else
    localparam int EXP_READS = 1024;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, video_rd_rdy, video_rd_en, udp_tx_start, udp_tx_valid, udp_tx_ready;
    logic        udp_tx_last, udp_tx_done;
    logic [9:0]  video_rd_data;
    logic [15:0] udp_tx_byte_num;
    logic [7:0]  udp_tx_data;

    logic        s_rdy, s_rd_en, s_start, s_valid, s_ready, s_last, s_done;
    logic [9:0]  s_rd_data;
    logic [15:0] s_byte_num;
    logic [7:0]  s_data;

    int vec = 0;
    int errs = 0;
    int rd_cnt = 0;
    int cons_idx = 0;
`ifdef VIDEO_PACKER_TEST_PATTERN_EN
    int tp_exp = 0;
`endif
    logic [9:0] pat [4] = '{10'h3FF, 10'h000, 10'h155, 10'h2AA};
    logic [7:0] pay0 [5];

    video_udp_packer dut (
        .video_rd_clk(clk), .rst_n(rst_n), .video_rd_rdy(video_rd_rdy), .video_rd_en(video_rd_en),
        .video_rd_data(video_rd_data), .udp_tx_start(udp_tx_start), .udp_tx_byte_num(udp_tx_byte_num),
        .udp_tx_data(udp_tx_data), .udp_tx_valid(udp_tx_valid), .udp_tx_ready(udp_tx_ready),
        .udp_tx_last(udp_tx_last), .udp_tx_done(udp_tx_done)
    );

    // Short packets so a whole frame of sequence numbers fits in a short run.
    video_udp_packer #(.PKT_WORDS(4), .PKT_PER_FRAME(PKT_PER_FRAME)) dut_s (
        .video_rd_clk(clk), .rst_n(rst_n), .video_rd_rdy(s_rdy), .video_rd_en(s_rd_en),
        .video_rd_data(s_rd_data), .udp_tx_start(s_start), .udp_tx_byte_num(s_byte_num),
        .udp_tx_data(s_data), .udp_tx_valid(s_valid), .udp_tx_ready(s_ready),
        .udp_tx_last(s_last), .udp_tx_done(s_done)
    );

    // FIFO model: pattern words, data one cycle after the read strobe.
    always @(posedge clk) begin
        if (video_rd_en === 1'b1) begin
            video_rd_data <= pat[rd_cnt % 4];
            rd_cnt <= rd_cnt + 1;
        end
        if (s_rd_en === 1'b1) s_rd_data <= s_rd_data + 10'd1;
    end

    task automatic next_word(output logic [9:0] w);
`ifdef VIDEO_PACKER_TEST_PATTERN_EN
        w = tp_exp[9:0];
        tp_exp++;
`else
        w = pat[cons_idx % 4];
        cons_idx++;
`endif
    endtask

    task automatic flush_model();
        cons_idx = rd_cnt;
`ifdef VIDEO_PACKER_TEST_PATTERN_EN
        tp_exp = 0;
`endif
    endtask

    task automatic recv_packet(input bit toggle, input logic [15:0] frm, input logic [15:0] pkt,
                               input int done_at, input int abort_at);
        int nb = 0;
        int cyc = 0;
        int rd0 = rd_cnt;
        bit fin = 1'b0;
        bit pend = 1'b0;
        bit done_sent = 1'b0;
        logic [7:0] held = '0;
        logic [7:0] expb;
        logic [39:0] grp = '0;
        logic [9:0] w0, w1, w2, w3;
        while (!fin && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            udp_tx_done = 1'b0;
            if (done_at >= 0 && nb >= done_at && !done_sent) begin
                udp_tx_done = 1'b1;
                done_sent = 1'b1;
            end
            if (pend) begin
                vec++;
                if (udp_tx_valid !== 1'b1 || udp_tx_data !== held) begin
                    errs++;
                    $display("FAIL stall_hold byte %0d: valid=%b data=%h, required valid=1 data=%h",
                             nb, udp_tx_valid, udp_tx_data, held);
                end
            end
            if (abort_at >= 0 && nb == abort_at) begin
                rst_n = 1'b0;
                udp_tx_ready = 1'b0;
                return;
            end
            udp_tx_ready = toggle ? cyc[0] : 1'b1;
            pend = 1'b0;
            if (udp_tx_valid === 1'b1) begin
                if (udp_tx_ready) begin
                    case (nb)
                        0: expb = frm[7:0];
                        1: expb = frm[15:8];
                        2: expb = pkt[7:0];
                        3: expb = pkt[15:8];
                        default: begin
                            if ((nb - 4) % 5 == 0) begin
                                next_word(w0); next_word(w1); next_word(w2); next_word(w3);
                                grp = {w3, w2, w1, w0};
                            end
                            expb = grp[8 * ((nb - 4) % 5) +: 8];
                        end
                    endcase
                    vec++;
                    if (udp_tx_data !== expb) begin
                        errs++;
                        $display("FAIL byte %0d: got %h, required %h", nb, udp_tx_data, expb);
                    end
                    vec++;
                    if (udp_tx_last !== (nb == PKT_BYTES - 1)) begin
                        errs++;
                        $display("FAIL last flag byte %0d: got %b", nb, udp_tx_last);
                    end
                    if (nb >= 4 && nb < 9) pay0[nb - 4] = udp_tx_data;
                    fin = udp_tx_last;
                    nb++;
                end else begin
                    pend = 1'b1;
                    held = udp_tx_data;
                end
            end
        end
        vec++;
        if (!fin || nb != PKT_BYTES) begin
            errs++;
            $display("FAIL byte_count: got %0d (last seen %b), required %0d", nb, fin, PKT_BYTES);
        end
        vec++;
        if (rd_cnt - rd0 != EXP_READS) begin
            errs++;
            $display("FAIL rd_count: got %0d, required %0d", rd_cnt - rd0, EXP_READS);
        end
    endtask

    task automatic finish_done();
        @(negedge clk);
        udp_tx_ready = 1'b0;
        udp_tx_done = 1'b1;
        @(negedge clk);
        udp_tx_done = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (udp_tx_start !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        vec++;
        if (udp_tx_start !== 1'b1) begin
            errs++;
            $display("FAIL %s start: timeout, udp_tx_start=%b", tag, udp_tx_start);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; video_rd_rdy = 1'b0; udp_tx_ready = 1'b0; udp_tx_done = 1'b0;
        s_rdy = 1'b0; s_ready = 1'b0; s_done = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if ({udp_tx_start, udp_tx_valid, udp_tx_last, video_rd_en, udp_tx_data} !== 12'd0) begin
            errs++;
            $display("FAIL reset outputs: start=%b valid=%b last=%b rd_en=%b data=%h, required all 0",
                     udp_tx_start, udp_tx_valid, udp_tx_last, video_rd_en, udp_tx_data);
        end
        vec++;
        if (udp_tx_byte_num !== 16'd0) begin
            errs++;
            $display("FAIL reset byte_num: got %0d, required 0", udp_tx_byte_num);
        end
    endtask

    task automatic test_first_packet();
        int k = 0;
        logic [7:0] exp0 [5];
`ifdef VIDEO_PACKER_TEST_PATTERN_EN
        exp0 = '{8'h00, 8'h04, 8'h20, 8'hC0, 8'h00};
`else
        // 0x3FF,0x000,0x155,0x2AA LSB-first; byte3 = 0x155[9:4] | 0x2AA[1:0]<<6.
        exp0 = '{8'hFF, 8'h03, 8'h50, 8'h95, 8'hAA};
`endif
        flush_model();
        video_rd_rdy = 1'b1;
        rst_n = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (udp_tx_start !== 1'b1 && k < 20);
        vec++;
        if (k != 2) begin
            errs++;
            $display("FAIL start_cycle: got %0d, required 2", k);
        end
        vec++;
        if (udp_tx_byte_num !== 16'd1284) begin
            errs++;
            $display("FAIL byte_num: got %0d, required 1284", udp_tx_byte_num);
        end
        recv_packet(1'b0, 16'd0, 16'd0, -1, -1);
        for (int i = 0; i < 5; i++) begin
            vec++;
            if (pay0[i] !== exp0[i]) begin
                errs++;
                $display("FAIL first_payload[%0d]: got %h, required %h", i, pay0[i], exp0[i]);
            end
        end
        finish_done();
    endtask

    task automatic test_backpressure();
        wait_start("backpressure");
        recv_packet(1'b1, 16'd0, 16'd1, 100, -1);
    endtask

    task automatic test_done_ignored();
        int k = 0;
        video_rd_rdy = 1'b0;
        finish_done();
`ifndef VIDEO_PACKER_TEST_PATTERN_EN
        udp_tx_done = 1'b1;
        @(negedge clk);
        udp_tx_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (udp_tx_start === 1'b1 || video_rd_en === 1'b1) k++;
        end
        vec++;
        if (k != 0) begin
            errs++;
            $display("FAIL wait_hold: %0d cycles with start/rd_en, required 0", k);
        end
`endif
        video_rd_rdy = 1'b1;
        wait_start("after_done");
        recv_packet(1'b0, 16'd0, 16'd2, -1, -1);
        finish_done();
    endtask

    task automatic test_reset_mid();
        int k = 0;
        wait_start("pre_abort");
        recv_packet(1'b0, 16'd0, 16'd3, -1, 600);
        @(negedge clk);
        vec++;
        if ({udp_tx_start, udp_tx_valid, udp_tx_last, video_rd_en, udp_tx_data} !== 12'd0) begin
            errs++;
            $display("FAIL midreset outputs: start=%b valid=%b last=%b rd_en=%b data=%h, required all 0",
                     udp_tx_start, udp_tx_valid, udp_tx_last, video_rd_en, udp_tx_data);
        end
        vec++;
        if (udp_tx_byte_num !== 16'd0) begin
            errs++;
            $display("FAIL midreset byte_num: got %0d, required 0", udp_tx_byte_num);
        end
        video_rd_rdy = 1'b0;
        rst_n = 1'b1;
        flush_model();
`ifndef VIDEO_PACKER_TEST_PATTERN_EN
        repeat (6) begin
            @(negedge clk);
            if (udp_tx_start === 1'b1 || video_rd_en === 1'b1) k++;
        end
        vec++;
        if (k != 0) begin
            errs++;
            $display("FAIL midreset no_start: %0d cycles with start/rd_en, required 0", k);
        end
`endif
        video_rd_rdy = 1'b1;
        wait_start("post_reset");
        recv_packet(1'b0, 16'd0, 16'd0, -1, -1);
        finish_done();
    endtask

    task automatic test_seq_wrap();
        int total = 0;
        int nb, cyc;
        bit fin;
        logic [7:0] h [4];
        logic [15:0] ef, ep;
        video_rd_rdy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        s_rdy = 1'b1;
        s_ready = 1'b1;
        rst_n = 1'b1;
        for (int p = 0; p <= PKT_PER_FRAME; p++) begin
            cyc = 0;
            while (s_start !== 1'b1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            if (s_start !== 1'b1) begin
                vec++;
                errs++;
                $display("FAIL wrap start timeout at packet %0d", p);
                return;
            end
            nb = 0; fin = 1'b0; cyc = 0;
            while (!fin && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (s_valid === 1'b1) begin
                    if (nb < 4) h[nb] = s_data;
                    nb++;
                    fin = s_last;
                end
            end
            total += nb;
            if (p == 0 || p == 1 || p == PKT_PER_FRAME - 1 || p == PKT_PER_FRAME) begin
                ef = 16'(p / PKT_PER_FRAME);
                ep = 16'(p % PKT_PER_FRAME);
                vec++;
                if ({h[3], h[2], h[1], h[0]} !== {ep, ef}) begin
                    errs++;
                    $display("FAIL wrap header pkt %0d: got pkt=%h frm=%h, required pkt=%h frm=%h",
                             p, {h[3], h[2]}, {h[1], h[0]}, ep, ef);
                end
            end
            @(negedge clk);
            s_done = 1'b1;
            @(negedge clk);
            s_done = 1'b0;
        end
        vec++;
        if (total != (PKT_PER_FRAME + 1) * 9) begin
            errs++;
            $display("FAIL wrap byte total: got %0d, required %0d", total, (PKT_PER_FRAME + 1) * 9);
        end
    endtask

    initial begin
        test_reset();
        test_first_packet();
        test_backpressure();
        test_done_ignored();
        test_reset_mid();
        test_seq_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
